// File: rtl/seq_mult8.sv
// Shift-and-add 8x8 unsigned multiplier built around one cla8 adder.
// Nine cycles from accepted start to a one-cycle done pulse; product held until the next start.

module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flat lookahead sum-of-products over all lower generate/propagate terms.
  always_comb begin
    logic t;
    logic pp;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      t  = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        t  = t | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = t | (pp & cin);
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

module seq_mult8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state;
  logic [7:0]  m;
  logic [7:0]  acc;
  logic [7:0]  q;
  logic [2:0]  cnt;

  logic [7:0]  addend;
  logic [7:0]  sum;
  logic        cout;
  logic [15:0] shifted;

  assign addend = q[0] ? m : 8'h00;

  cla8 u_cla8 (
    .a    (acc),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Carry and sum shift right into the {acc, q} pair; q[0] drops out as consumed.
  assign shifted = {cout, sum, q[7:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      m       <= 8'h00;
      acc     <= 8'h00;
      q       <= 8'h00;
      cnt     <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 16'h0000;
    end else begin
      case (state)
        StCalc: begin
          {acc, q} <= shifted;
          cnt      <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state   <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= shifted;
          end
        end
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= 8'h00;
            cnt   <= 3'd0;
            state <= StCalc;
            busy  <= 1'b1;
          end else begin
            state <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult8.sv
// Self-checking bench for seq_mult8: directed corner cases plus random operands
// against a plain arithmetic product/latency model.

module tb_seq_mult8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_cmp;
  int n_err;

  localparam int ExpBusy = 8;
  localparam int ExpDone = 9;
  localparam int Bound   = 30;

  seq_mult8 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_mul(input logic [7:0] x, input logic [7:0] y);
    int unsigned r;
    r = int'(x) * int'(y);
    return r[15:0];
  endfunction

  // Pulses start for one cycle, scrambles the operands, and measures busy length,
  // done cycle (counted from the accepting edge as cycle 1) and whether product held.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, output int busy_cnt,
                        output int done_cyc, output logic [15:0] prod, output bit held,
                        output bit timeout);
    logic [15:0] prev;
    int k;
    busy_cnt = 0;
    done_cyc = 0;
    held     = 1'b1;
    timeout  = 1'b1;
    prod     = 16'hxxxx;
    @(negedge clk);
    prev  = product;
    start = 1'b1;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    k     = 1;
    while (k <= Bound) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (done) begin
        done_cyc = k;
        prod     = product;
        timeout  = 1'b0;
        break;
      end
      if (busy) busy_cnt++;
      if (product !== prev) held = 1'b0;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_op(input string name, input logic [7:0] x, input logic [7:0] y);
    int bc, dc;
    logic [15:0] pr;
    bit hd, to;
    logic [15:0] exp;
    exp = model_mul(x, y);
    run_op(x, y, bc, dc, pr, hd, to);
    n_cmp++;
    if (to) begin
      n_err++;
      $display("FAIL %s timeout: no done within %0d cycles", name, Bound);
      return;
    end
    n_cmp++;
    if (bc !== ExpBusy) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, bc, ExpBusy);
    end
    n_cmp++;
    if (dc !== ExpDone) begin
      n_err++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, dc, ExpDone);
    end
    n_cmp++;
    if (pr !== exp) begin
      n_err++;
      $display("FAIL %s product: got %h want %h", name, pr, exp);
    end
    n_cmp++;
    if (!hd) begin
      n_err++;
      $display("FAIL %s product_hold: changed before done", name);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || product !== exp) begin
      n_err++;
      $display("FAIL %s after_done: done=%b product=%h want done=0 product=%h",
               name, done, product, exp);
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, product} !== 18'h0) begin
      n_err++;
      $display("FAIL reset_async: busy=%b done=%b product=%h want 0/0/0000", busy, done, product);
    end
    // start during reset must be ignored
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_start_ignored: busy=%b done=%b product=%h want 0/0/0000",
               busy, done, product);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_hold: busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_directed();
    check_op("d_0d_0b", 8'h0D, 8'h0B);
    check_op("d_ff_ff", 8'hFF, 8'hFF);
    check_op("d_00_ff", 8'h00, 8'hFF);
    check_op("d_a5_00", 8'hA5, 8'h00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      check_op($sformatf("rand%0d", i), 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_ignore_start();
    int k;
    bit got;
    @(negedge clk);
    start = 1'b1;
    a     = 8'h03;
    b     = 8'h04;
    @(negedge clk);
    start = 1'b0;
    k     = 1;
    got   = 1'b0;
    while (k <= Bound) begin
      if (k == 3) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    n_cmp++;
    if (!got || k !== ExpDone) begin
      n_err++;
      $display("FAIL ignore_start_done_cycle: got %0d want %0d", got ? k : -1, ExpDone);
    end
    n_cmp++;
    if (product !== model_mul(8'h03, 8'h04)) begin
      n_err++;
      $display("FAIL ignore_start_product: got %h want %h", product, model_mul(8'h03, 8'h04));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int k;
    bit got;
    @(negedge clk);
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h10;
    k     = 0;
    got   = 1'b0;
    while (k < Bound) begin
      @(negedge clk);
      k++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!got || k !== ExpDone || product !== model_mul(8'h10, 8'h10)) begin
      n_err++;
      $display("FAIL b2b_first: done_cycle=%0d product=%h want %0d/%h", got ? k : -1, product,
               ExpDone, model_mul(8'h10, 8'h10));
    end
    a = 8'h02;
    b = 8'h80;
    @(negedge clk);
    start = 1'b0;
    a     = 8'h55;
    b     = 8'h55;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || product !== model_mul(8'h10, 8'h10)) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b done=%b product=%h want 1/0/%h", busy, done, product,
               model_mul(8'h10, 8'h10));
    end
    k   = 1;
    got = 1'b0;
    while (k <= Bound) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!got || k !== ExpDone || product !== model_mul(8'h02, 8'h80)) begin
      n_err++;
      $display("FAIL b2b_second: done_cycle=%0d product=%h want %0d/%h", got ? k : -1, product,
               ExpDone, model_mul(8'h02, 8'h80));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    @(negedge clk);
    start = 1'b1;
    a     = 8'($urandom_range(1, 255));
    b     = 8'($urandom_range(1, 255));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_mid_async: busy=%b done=%b product=%h want 0/0/0000",
               busy, done, product);
    end
    @(negedge clk);
    rst       = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done || product !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_mid_abandon: activity=%b product=%h want 0/0000", seen_done, product);
    end
    check_op("post_reset_07_06", 8'h07, 8'h06);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
